ttl_crc16_seq: RTL



---
 rtl/ttl_crc16_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/ttl_crc16_seq.sv
// Bit-serial CRC-16 sequencer: byte shift register, CRC register and bit counter
// run by a small IDLE/SHIFT/DONE FSM that folds one data bit per clock.
module ttl_crc16_seq #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        init,
  input  logic        ld,
  input  logic [7:0]  d,
  output logic        busy,
  output logic        rdy,
  output logic [15:0] crc,
  output logic        zero
);

  localparam int unsigned CRC_W = 16;
  localparam int unsigned SR_W  = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   w_crc_nxt;
  logic [SR_W-1:0]    r_sr;
  logic [SR_W-1:0]    w_sr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               r_rdy;
  logic               r_zero;
  logic               w_busy_nxt;
  logic               w_rdy_nxt;
  logic               w_zero_nxt;
  logic               w_fb;

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ld) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(7)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fb = r_crc[CRC_W-1] ^ r_sr[SR_W-1];

  // Datapath and output next values; init/ld only act in IDLE
  always_comb begin
    w_crc_nxt = r_crc;
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (init) w_crc_nxt = INIT;
        if (ld) begin
          w_sr_nxt  = d;
          w_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : CRC_W'(0));
        w_sr_nxt  = {r_sr[SR_W-2:0], 1'b0};
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_rdy_nxt  = (w_state_nxt == S_DONE);
    w_zero_nxt = (w_state_nxt == S_IDLE) && (w_crc_nxt == CRC_W'(0));
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_crc  <= INIT;
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_rdy  <= 1'b0;
      r_zero <= (INIT == CRC_W'(0));
    end else begin
      r_crc  <= w_crc_nxt;
      r_sr   <= w_sr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_rdy  <= w_rdy_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign busy = r_busy;
  assign rdy  = r_rdy;
  assign crc  = r_crc;
  assign zero = r_zero;

endmodule
